// File: rtl/rw_read_sched_if.sv
// ---------------------------------------------------------------------------
// rw_read_sched_if
//
// Purpose: bundles every handshake and status signal of the read-RW thread
// scheduler so the scheduler and its surroundings share one definition.
//
// Signal groups:
//   requester side : req_valid, req_ready, req_task, req_cq_slot
//   task output    : task_out_valid, task_out_ready, task_out, cq_slot_out,
//                    thread_id_out
//   thread return  : free_valid, free_thread
//   status         : n_free, busy
//
// Modports:
//   slave  - the scheduler itself (drives req_ready, the task output and
//            the status signals).
//   master - the environment around it (requesters, the downstream read-RW
//            stage and the thread retire path).
// ---------------------------------------------------------------------------
interface rw_read_sched_if #(
  parameter int N_REQ  = 4,
  parameter int N_TH   = 8,
  parameter int TASK_W = 32,
  parameter int SLOT_W = 4
);
  localparam int TH_W  = $clog2(N_TH);
  localparam int CNT_W = TH_W + 1;

  // requester side
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][TASK_W-1:0] req_task;
  logic [N_REQ-1:0][SLOT_W-1:0] req_cq_slot;

  // registered task output
  logic                         task_out_valid;
  logic                         task_out_ready;
  logic [TASK_W-1:0]            task_out;
  logic [SLOT_W-1:0]            cq_slot_out;
  logic [TH_W-1:0]              thread_id_out;

  // thread return
  logic                         free_valid;
  logic [TH_W-1:0]              free_thread;

  // status
  logic [CNT_W-1:0]             n_free;
  logic                         busy;

  modport slave (
    input  req_valid, req_task, req_cq_slot, task_out_ready,
           free_valid, free_thread,
    output req_ready, task_out_valid, task_out, cq_slot_out, thread_id_out,
           n_free, busy
  );

  modport master (
    output req_valid, req_task, req_cq_slot, task_out_ready,
           free_valid, free_thread,
    input  req_ready, task_out_valid, task_out, cq_slot_out, thread_id_out,
           n_free, busy
  );
endinterface

// File: rtl/rw_read_sched.sv
// ---------------------------------------------------------------------------
// rw_read_sched
//
// Purpose: thread-allocating arbiter in front of the read-RW stage. Each
// cycle it picks at most one requester round-robin, binds its task to the
// lowest-numbered free read-thread ID and presents {task, CQ slot, thread}
// on a registered valid/ready output. Threads come back to the pool through
// the free port when the downstream stage retires them.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rstn  - synchronous active-low reset
//   bus   - rw_read_sched_if.slave: requester handshake, task output,
//           thread free port, n_free / busy status
//
// Parameters:
//   N_REQ         - number of requesters (>= 2)
//   N_TH          - thread pool size (>= 2)
//   TASK_W        - task descriptor width
//   SLOT_W        - CQ slot width
//   REPORT_ERRORS - 1 enables simulation messages on illegal frees
// ---------------------------------------------------------------------------
module rw_read_sched #(
  parameter int N_REQ         = 4,
  parameter int N_TH          = 8,
  parameter int TASK_W        = 32,
  parameter int SLOT_W        = 4,
  parameter bit REPORT_ERRORS = 1'b1
) (
  input  logic           clk,
  input  logic           rstn,
  rw_read_sched_if.slave bus
);
  localparam int TH_W  = $clog2(N_TH);
  localparam int RR_W  = $clog2(N_REQ);
  localparam int CNT_W = TH_W + 1;

  localparam logic [RR_W:0]    N_REQ_W  = (RR_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] N_TH_CNT = CNT_W'(N_TH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_TH-1:0]   fmap_reg,       fmap_next;
  logic [RR_W-1:0]   rr_reg,         rr_next;
  logic [CNT_W-1:0]  n_free_reg,     n_free_next;
  logic              out_valid_reg,  out_valid_next;
  logic [TASK_W-1:0] out_task_reg,   out_task_next;
  logic [SLOT_W-1:0] out_slot_reg,   out_slot_next;
  logic [TH_W-1:0]   out_thread_reg, out_thread_next;

  // -------------------------------------------------------------------------
  // Round-robin winner search
  // -------------------------------------------------------------------------
  logic            any_req;
  logic [RR_W-1:0] win;
  logic [RR_W:0]   idx_wide;

  // Offsets are scanned from the far end back toward rr so that the
  // nearest asserted requester (smallest offset from rr) is written last.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    idx_wide = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_wide = {1'b0, rr_reg} + (RR_W+1)'(i);
      if (idx_wide >= N_REQ_W) begin
        idx_wide = idx_wide - N_REQ_W;
      end
      if (bus.req_valid[idx_wide[RR_W-1:0]]) begin
        any_req = 1'b1;
        win     = idx_wide[RR_W-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Thread allocation: lowest-index free thread in the registered bitmap
  // -------------------------------------------------------------------------
  logic [TH_W-1:0] alloc_id;

  always_comb begin
    alloc_id = '0;
    for (int i = N_TH - 1; i >= 0; i--) begin
      if (fmap_reg[i]) begin
        alloc_id = TH_W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant decision
  // -------------------------------------------------------------------------
  logic out_slot_free;
  logic load_ok;
  logic grant;

  // The output register can take a new task when it is empty or being
  // drained this cycle; a task is only accepted if a thread is available.
  // rstn gates the grant so req_ready stays low while reset is held.
  assign out_slot_free = !out_valid_reg || bus.task_out_ready;
  assign load_ok       = out_slot_free && (fmap_reg != '0);
  assign grant         = rstn && load_ok && any_req;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = grant && (win == RR_W'(gi));
  end

  // -------------------------------------------------------------------------
  // Free port validation
  // -------------------------------------------------------------------------
  // free_match is one-hot on a legal ID and all-zero for an ID beyond the
  // pool, which doubles as the range check.
  logic [N_TH-1:0] free_match;
  logic            free_in_range;
  logic            free_already;
  logic            free_ok;
  logic            free_err;

  for (genvar gi = 0; gi < N_TH; gi++) begin : g_free_match
    assign free_match[gi] = (bus.free_thread == TH_W'(gi));
  end

  assign free_in_range = |free_match;
  assign free_already  = |(free_match & fmap_reg);
  assign free_ok       = bus.free_valid && free_in_range && !free_already;
  assign free_err      = bus.free_valid && !(free_in_range && !free_already);

  // -------------------------------------------------------------------------
  // Next-state: bitmap, pointer, counter
  // -------------------------------------------------------------------------
  // A freed thread is never the one being allocated (it is not free in the
  // registered bitmap), so clear and set never collide on the same bit.
  for (genvar gi = 0; gi < N_TH; gi++) begin : g_fmap_next
    assign fmap_next[gi] = (fmap_reg[gi] && !(grant && (alloc_id == TH_W'(gi))))
                         || (free_ok && free_match[gi]);
  end

  always_comb begin
    rr_next = rr_reg;
    if (grant) begin
      rr_next = (win == RR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    n_free_next = n_free_reg;
    case ({grant, free_ok})
      2'b10:   n_free_next = n_free_reg - 1'b1;
      2'b01:   n_free_next = n_free_reg + 1'b1;
      default: n_free_next = n_free_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state: output register
  // -------------------------------------------------------------------------
  // A grant reloads the register, which also covers drain-and-refill on the
  // same edge. Without a grant a drained entry just goes invalid; the data
  // fields keep their last value.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_task_next   = out_task_reg;
    out_slot_next   = out_slot_reg;
    out_thread_next = out_thread_reg;
    if (grant) begin
      out_valid_next  = 1'b1;
      out_task_next   = bus.req_task[win];
      out_slot_next   = bus.req_cq_slot[win];
      out_thread_next = alloc_id;
    end else if (out_valid_reg && bus.task_out_ready) begin
      out_valid_next  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fmap_reg       <= '1;
      rr_reg         <= '0;
      n_free_reg     <= N_TH_CNT;
      out_valid_reg  <= 1'b0;
      out_task_reg   <= '0;
      out_slot_reg   <= '0;
      out_thread_reg <= '0;
    end else begin
      fmap_reg       <= fmap_next;
      rr_reg         <= rr_next;
      n_free_reg     <= n_free_next;
      out_valid_reg  <= out_valid_next;
      out_task_reg   <= out_task_next;
      out_slot_reg   <= out_slot_next;
      out_thread_reg <= out_thread_next;
    end
  end

  // Illegal frees are dropped by the logic above; this only reports them.
  always_ff @(posedge clk) begin
    if (REPORT_ERRORS && rstn) begin
      assert (!free_err)
        else $error("rw_read_sched: illegal free of thread %0d", bus.free_thread);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.task_out_valid = out_valid_reg;
  assign bus.task_out       = out_task_reg;
  assign bus.cq_slot_out    = out_slot_reg;
  assign bus.thread_id_out  = out_thread_reg;
  assign bus.n_free         = n_free_reg;
  assign bus.busy           = out_valid_reg || (n_free_reg != N_TH_CNT);

endmodule

// File: doc/rw_read_sched.md
# rw_read_sched

Thread-allocating arbiter in front of the read-RW stage. Collects tasks from `N_REQ` requesters, picks one per cycle round-robin, and binds it to a free read-thread ID. Presents task, CQ slot and thread ID on a registered valid/ready output that feeds the read-RW `task_in` port. Thread IDs return to the pool through a free port driven when the downstream stage retires a thread.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2).
- `N_TH`, `N_THREADS`, size of the thread pool; thread ID width is `$clog2(N_TH)` (= `thread_id_t`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `req_valid`  in  [N_REQ]  per-requester task valid.
- `req_ready`  out  [N_REQ]  per-requester accept; one-hot or zero.
- `req_task`  in  task_t [N_REQ]  per-requester task descriptor.
- `req_cq_slot`  in  cq_slice_slot_t [N_REQ]  per-requester CQ slot.
- `task_out_valid`  out  1  registered task available.
- `task_out_ready`  in  1  downstream accepts.
- `task_out`  out  task_t  granted task.
- `cq_slot_out`  out  cq_slice_slot_t  granted CQ slot.
- `thread_id_out`  out  thread_id_t  allocated thread.
- `free_valid`  in  1  return one thread to the pool.
- `free_thread`  in  thread_id_t  ID being returned.
- `n_free`  out  $clog2(N_TH)+1  registered count of free threads.
- `busy`  out  1  `task_out_valid | (n_free != N_TH)`.

## Operation
- State: free bitmap `fmap[N_TH]` (1 = free), one output register (valid + task + slot + thread), round-robin pointer `rr` (`$clog2(N_REQ)` bits), `n_free` counter.
- Load enable: `load_ok = (!task_out_valid | task_out_ready) & (fmap != 0)`.
- Grant: when `load_ok` and any `req_valid`, winner `w` is the first asserted `req_valid` scanning from `rr` upward, modulo `N_REQ`. Drive `req_ready[w]=1` and all others 0. Otherwise `req_ready` is all zero.
  - `req_ready` is combinational from `req_valid`, `task_out_valid`, `task_out_ready` and registered `fmap`.
- On grant, next edge:
  - Output register ← {`req_task[w]`, `req_cq_slot[w]`, `t`}, where `t` is the lowest-index set bit of `fmap`.
  - `fmap[t]` ← 0.
  - `rr` ← (w+1) mod N_REQ.
- Pointer hold: `rr` is unchanged when there is no grant.
- Output drain: `task_out_valid & task_out_ready` without a grant → `task_out_valid` ← 0.
- Output hold: contents stay stable while `task_out_valid & !task_out_ready`.
- Free: `free_valid` → `fmap[free_thread]` ← 1 at next edge.
- Same-cycle alloc + free:
  - Allocation uses the registered `fmap`, so a thread freed this cycle cannot be allocated until the next cycle.
  - If the allocated and freed IDs differ, both updates apply.
  - They cannot be equal: the freed ID is not free in `fmap`.
- `n_free` next = `n_free` − grant + `free_valid`; it holds when both occur.
- Error cases (simulation `$error`, RTL ignores the free and leaves state unchanged):
  - free of an already-free thread;
  - `free_thread ≥ N_TH`.
- Pool empty (`fmap==0`): no grants, all `req_ready`=0. An already-valid output still drains normally.

## Timing
- Reset values (`rstn`=0 at an edge):
  - `fmap` all 1; `n_free`=N_TH; `rr`=0.
  - `task_out_valid`=0; `task_out`, `cq_slot_out`, `thread_id_out`=0.
  - `busy`=0; `req_ready` all 0 during reset.
- Reset mid-operation drops the buffered task and all allocations. Upstream and downstream are reset together.
- Latency: request accepted at edge t → `task_out_valid`=1 from t+1.
- Throughput: one task/cycle while `task_out_ready`=1 and the pool is non-empty (pass-through on the same edge as drain).
- Free latency: `free_valid` at edge t → thread allocatable for a grant evaluated in cycle t+1.
- Back-pressure: `task_out_ready`=0 with a valid output → `req_ready`=0 next cycle.
- Requester side follows valid/ready: a requester holds `req_valid` and data until its `req_ready`.

## Test plan
- Reset, N_TH=4, N_REQ=4, all `req_valid`=1, `task_out_ready`=1 → grants to requesters 0,1,2,3 on consecutive cycles. Threads 0,1,2,3 appear at `thread_id_out`. `n_free` reaches 0, then `req_ready`=0.
- Pool empty, `free_valid` with thread 2 at cycle t and requester 1 valid → grant in cycle t+1. `thread_id_out`=2 at t+2; `n_free` goes 0→1→0.
- `task_out_ready`=0 for 5 cycles with output valid → output fields stable, `req_ready`=0 throughout. Release → drain and new grant on the same edge, `task_out_valid` stays 1.
- Requesters 0 and 2 continuously valid, `rr`=1 → grants alternate 2,0,2,0. Requester 1 raising `req_valid` after a grant to 0 is granted next.
- Same-cycle grant (allocates thread 0) and free of thread 3 → `fmap` loses bit 0 and gains bit 3. `n_free` unchanged.
- Double free of thread 1 while it is free → `$error` fires, `fmap` and `n_free` unchanged. Reset asserted with output valid → `task_out_valid`=0 and `n_free`=N_TH the next cycle.
